rnw1_port_ram: RTL and testbench
================================

Name: rnw1_port_ram

Overview:
- Parametrised multi-read, single-write RAM: READ_PORTS independent synchronous read ports sharing one write port. Built as one replicated memory bank per read port, all written identically.
- Adds write-to-read bypass, a hardware clear sequencer and a busy flag.
- Used for CPU register files and shared lookup tables that need more than two simultaneous reads.

Parameters:
- DATA_WIDTH, 8, bits per word
- ADDR_WIDTH, 12, address bits; depth = 2^ADDR_WIDTH
- READ_PORTS, 2, number of read ports (>=1)
- CLEAR_VALUE, 0, word written to every location by the clear sequencer

Ports:
- clk  in  1  single clock; all logic on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- clear_req  in  1  one-cycle pulse; starts or restarts the clear sequence
- addr_r  in  READ_PORTS*ADDR_WIDTH  read addresses, port k at bits [k*ADDR_WIDTH +: ADDR_WIDTH]
- addr_w  in  ADDR_WIDTH  write address
- data_in  in  DATA_WIDTH  write data
- we  in  1  write enable
- data_out  out  READ_PORTS*DATA_WIDTH  read data, port k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- busy  out  1  high while the clear sequence runs

Behaviour:
- Reset (reset_n=0, asynchronous):
  - data_out=0, busy=1, FSM=CLEAR, clear counter=0.
  - Memory contents are not reset directly; they are cleared by the FSM after release.
- FSM states:
  - CLEAR: each cycle writes CLEAR_VALUE to address cnt in every bank, then cnt++.
  - When cnt = 2^ADDR_WIDTH-1 is written, go to READY next cycle and set busy=0.
  - Sequence length is exactly 2^ADDR_WIDTH cycles after reset release.
  - READY: normal operation. clear_req=1 -> CLEAR, cnt=0, busy=1 on the next edge.
  - clear_req asserted during CLEAR: cnt restarts at 0.
- During CLEAR:
  - External we is ignored; the write is dropped, not queued.
  - data_out is held at 0.
- Read, READY state:
  - data_out[k] is registered with latency 1: the value at addr_r[k] sampled at edge N appears after edge N.
  - Ports are fully independent; any ports may read the same address.
- Write, READY state: we=1 writes data_in to addr_w in all banks at the edge.
- Bypass (write-first):
  - If we=1 and addr_r[k]==addr_w in the same cycle, data_out[k] = data_in after that edge, not the old contents.
  - Applies per port independently.
- Wrap-around: clear counter is ADDR_WIDTH+1 bits wide to detect the terminal address; there is no address wrap in normal operation.
- Reset mid-clear or mid-operation: immediate return to the reset state above; the clear restarts from address 0.

Optional Feature:
- Macro: RNW1_PORT_RAM_OUTREG_EN
- Defined:
  - An additional output register stage is added per port; read latency is 2.
  - Bypass compares against the write of the sampling cycle, so data_out shows data_in 2 cycles after the edge.
  - The extra stage resets to 0 and is forced to 0 during CLEAR.
- Undefined: read latency 1 as above. No extra registers.

Test Plan:
- Reset release, ADDR_WIDTH=4 -> busy=1 for exactly 16 cycles, then 0; reading addresses 0..15 on all ports returns CLEAR_VALUE.
- READY, write 0xA5 to addr 3, next cycle READ_PORTS=4 all read addr 3 -> all four data_out = 0xA5 one cycle later.
- Same cycle: we=1, addr_w=7, data_in=0x3C, port0 addr 7, port1 addr 8 (holding 0x11) -> next cycle port0=0x3C (bypass), port1=0x11.
- clear_req pulsed 5 cycles into a clear, with a write of 0xFF to addr 2 attempted during the clear -> busy stays high 16 more cycles; addr 2 reads CLEAR_VALUE afterwards.
- reset_n asserted asynchronously between edges while data_out=0x5A -> data_out=0 and busy=1 immediately; the clear reruns fully after release.
- RNW1_PORT_RAM_OUTREG_EN defined, write 0x77 to addr 1 then read addr 1 -> 0x77 appears 2 cycles after the read address is sampled.

Source files
------------

// File: rtl/rnw1_port_ram.sv
// rtl/rnw1_port_ram.sv - multi-read single-write RAM with write-first bypass and clear sequencer (option: RNW1_PORT_RAM_OUTREG_EN)
module rnw1_port_ram #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    ADDR_WIDTH  = 12,
    parameter int                    READ_PORTS  = 2,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             clear_req,
    input  logic [READ_PORTS*ADDR_WIDTH-1:0] addr_r,
    input  logic [ADDR_WIDTH-1:0]            addr_w,
    input  logic [DATA_WIDTH-1:0]            data_in,
    input  logic                             we,
    output logic [READ_PORTS*DATA_WIDTH-1:0] data_out,
    output logic                             busy
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] LAST_CNT = {1'b0, {ADDR_WIDTH{1'b1}}};

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_t;

    state_t              state;
    logic [ADDR_WIDTH:0] cnt;

    logic                  clearing;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    // Sequencer owns the write port while clearing; external writes are dropped then.
    assign clearing  = (state == ST_CLEAR);
    assign mem_we    = clearing | we;
    assign mem_waddr = clearing ? cnt[ADDR_WIDTH-1:0] : addr_w;
    assign mem_wdata = clearing ? CLEAR_VALUE : data_in;

    // Clear sequencer: sweep every address once, restart on clear_req.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_CLEAR;
            cnt   <= '0;
            busy  <= 1'b1;
        end else begin
            case (state)
                ST_CLEAR: begin
                    if (clear_req) begin
                        cnt <= '0;
                    end else if (cnt == LAST_CNT) begin
                        state <= ST_READY;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_READY: begin
                    if (clear_req) begin
                        state <= ST_CLEAR;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_CLEAR;
                    cnt   <= '0;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

    for (genvar k = 0; k < READ_PORTS; k++) begin : g_port
        logic [DATA_WIDTH-1:0] mem [DEPTH];
        logic [ADDR_WIDTH-1:0] ra;
        logic [DATA_WIDTH-1:0] rd_q;

        assign ra = addr_r[k*ADDR_WIDTH +: ADDR_WIDTH];

        // Replicated bank: every bank sees the same write so each port reads independently.
        always_ff @(posedge clk) begin
            if (mem_we) begin
                mem[mem_waddr] <= mem_wdata;
            end
        end

        // Registered read with write-first bypass; held at zero while clearing.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                rd_q <= '0;
            end else if (clearing) begin
                rd_q <= '0;
            end else if (we && (ra == addr_w)) begin
                rd_q <= data_in;
            end else begin
                rd_q <= mem[ra];
            end
        end

`ifdef RNW1_PORT_RAM_OUTREG_EN
        logic [DATA_WIDTH-1:0] out_q;

        // Extra output stage, also forced to zero while clearing.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                out_q <= '0;
            end else if (clearing) begin
                out_q <= '0;
            end else begin
                out_q <= rd_q;
            end
        end

        assign data_out[k*DATA_WIDTH +: DATA_WIDTH] = out_q;
`else
        assign data_out[k*DATA_WIDTH +: DATA_WIDTH] = rd_q;
`endif
    end

endmodule

// File: tb/tb_rnw1_port_ram.sv
// tb/tb_rnw1_port_ram.sv - directed self-checking bench for rnw1_port_ram
module tb_rnw1_port_ram;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int RP = 4;
    localparam logic [DW-1:0] CV = 8'hC3;
`ifdef RNW1_PORT_RAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic              clk;
    logic              reset_n;
    logic              clear_req;
    logic [RP*AW-1:0]  addr_r;
    logic [AW-1:0]     addr_w;
    logic [DW-1:0]     data_in;
    logic              we;
    logic [RP*DW-1:0]  data_out;
    logic              busy;

    int checks;
    int failures;

    rnw1_port_ram #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .READ_PORTS (RP),
        .CLEAR_VALUE(CV)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear_req(clear_req),
        .addr_r   (addr_r),
        .addr_w   (addr_w),
        .data_in  (data_in),
        .we       (we),
        .data_out (data_out),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                            input logic [AW-1:0] a2, input logic [AW-1:0] a3);
        addr_r = {a3, a2, a1, a0};
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        addr_w  = a;
        data_in = d;
        we      = 1'b1;
        tick();
        we      = 1'b0;
    endtask

    // Ticks until busy drops, bounded; returns the number of edges taken.
    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic read_all(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d);
        set_addr(a, a, a, a);
        for (int i = 0; i < LAT; i++) tick();
        check(tag, data_out, {RP{d}});
    endtask

    initial begin
        int n;
        checks    = 0;
        failures  = 0;
        reset_n   = 1'b1;
        clear_req = 1'b0;
        addr_r    = '0;
        addr_w    = '0;
        data_in   = '0;
        we        = 1'b0;

        #1 reset_n = 1'b0;
        #1;
        check("rst_dout", data_out, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h1);
        #10 reset_n = 1'b1;

        count_busy(n);
        check("clear_len", n, 16);
        for (int a = 0; a < 16; a++) read_all("clear_val", AW'(a), CV);

        set_addr(0, 0, 0, 0);
        wr(4'd3, 8'hA5);
        read_all("rd4_addr3", 4'd3, 8'hA5);

        set_addr(0, 0, 0, 0);
        wr(4'd8, 8'h11);
        set_addr(4'd7, 4'd8, 4'd3, 4'd7);
        addr_w  = 4'd7;
        data_in = 8'h3C;
        we      = 1'b1;
        tick();
        we      = 1'b0;
        for (int i = 1; i < LAT; i++) tick();
        check("bypass", data_out, {8'h3C, 8'hA5, 8'h11, 8'h3C});
        read_all("after_byp", 4'd7, 8'h3C);

        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        check("clr_busy", {31'b0, busy}, 32'h1);
        addr_w  = 4'd2;
        data_in = 8'hFF;
        we      = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("clr_dout0", data_out, 32'h0);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        count_busy(n);
        we = 1'b0;
        check("restart_len", n, 16);
        read_all("clr_addr2", 4'd2, CV);
        read_all("clr_addr3", 4'd3, CV);
        read_all("clr_addr7", 4'd7, CV);

        set_addr(0, 0, 0, 0);
        wr(4'd9, 8'h5A);
        read_all("pre_rst", 4'd9, 8'h5A);
        #2 reset_n = 1'b0;
        #1;
        check("arst_dout", data_out, 32'h0);
        check("arst_busy", {31'b0, busy}, 32'h1);
        #2 reset_n = 1'b1;
        count_busy(n);
        check("rerun_len", n, 16);
        read_all("rerun_a9", 4'd9, CV);

        set_addr(0, 0, 0, 0);
        wr(4'd1, 8'h77);
        for (int i = 0; i < LAT; i++) tick();
        set_addr(4'd1, 4'd1, 4'd1, 4'd1);
        tick();
        check("lat_edge1", {24'b0, data_out[DW-1:0]}, (LAT == 1) ? 32'h77 : {24'b0, CV});
        tick();
        check("lat_edge2", {24'b0, data_out[DW-1:0]}, 32'h77);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
